// File: rtl/pipeline_spi_layer_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_spi_pkg
//  Purpose  : Shared constants and helpers for the layered SPI register file:
//             register indices, command-byte field positions, argument-count
//             decode and RESET default values.
//  Revision : 1.0  initial release
// ============================================================================
package pipeline_spi_pkg;

    // Command byte layout: [7] read, [6:4] layer, [3:0] register
    localparam int c_CMD_READ_BIT  = 7;
    localparam int c_CMD_LAYER_MSB = 6;
    localparam int c_CMD_LAYER_LSB = 4;
    localparam int c_CMD_REG_MSB   = 3;
    localparam int c_CMD_REG_LSB   = 0;

    // Register indices
    localparam logic [3:0] c_REG_RESET   = 4'h0;
    localparam logic [3:0] c_REG_MODE    = 4'h1;
    localparam logic [3:0] c_REG_FLAGS   = 4'h2;
    localparam logic [3:0] c_REG_SCALE   = 4'h3;
    localparam logic [3:0] c_REG_OFFX    = 4'h4;
    localparam logic [3:0] c_REG_OFFY    = 4'h5;
    localparam logic [3:0] c_REG_OPACITY = 4'h6;
    localparam logic [3:0] c_REG_CLIPL   = 4'h7;
    localparam logic [3:0] c_REG_CLIPR   = 4'h8;
    localparam logic [3:0] c_REG_CLIPT   = 4'h9;
    localparam logic [3:0] c_REG_CLIPB   = 4'hA;
    localparam logic [3:0] c_REG_FREEZE  = 4'hB;
    localparam logic [3:0] c_REG_STATUS  = 4'hE;
    localparam logic [3:0] c_REG_NOP     = 4'hF;

    // RESET defaults for fixed-width fields; offsets and clips reset to zero,
    // opacity resets to all ones at whatever width the bank is built with.
    localparam logic [1:0] c_DEF_MODE   = 2'b00;
    localparam logic [1:0] c_DEF_SCALE  = 2'b00;
    localparam logic [7:0] c_DEF_FLAGS  = 8'h00;
    localparam logic       c_DEF_FREEZE = 1'b0;

    // Number of argument bytes following a command byte. Reads consume the
    // same count as dummy bytes, except STATUS which is 2 on read, 0 on write.
    function automatic logic [1:0] arg_count(input logic [3:0] reg_idx,
                                             input logic       is_read);
        logic [1:0] n;
        n = 2'd0;
        case (reg_idx)
            c_REG_MODE, c_REG_FLAGS, c_REG_SCALE,
            c_REG_OPACITY, c_REG_FREEZE:               n = 2'd1;
            c_REG_OFFX, c_REG_OFFY, c_REG_CLIPL,
            c_REG_CLIPR, c_REG_CLIPT, c_REG_CLIPB:     n = 2'd2;
            c_REG_STATUS:                              n = is_read ? 2'd2 : 2'd0;
            default:                                   n = 2'd0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_spi_layer_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_spi_layer_regfile_if
//  Purpose  : Byte-stream link between spi_slave (master side) and the layer
//             register file (slave side).
//  Revision : 1.0  initial release
// ============================================================================
interface pipeline_spi_layer_regfile_if;
    logic       spi_active;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [7:0] tx_byte;
    logic       tx_valid;

    modport master (output spi_active, byte_in, byte_valid,
                    input  tx_byte, tx_valid);
    modport slave  (input  spi_active, byte_in, byte_valid,
                    output tx_byte, tx_valid);
endinterface
`default_nettype wire

// File: rtl/pipeline_spi_layer_regfile_bank.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_spi_layer_bank
//  Purpose  : One overlay layer's shadow and live control registers with a
//             write port, a shadow read mux and a commit strobe.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_spi_layer_bank
    import pipeline_spi_pkg::*;
#(
    parameter int PRECISION              = 11,
    parameter int TRANSPARENCY_PRECISION = 3,
    parameter int ARG_W                  = 12
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              i_wr_en,
    input  wire logic [3:0]                        i_wr_reg,
    input  wire logic [ARG_W-1:0]                  i_wr_data,
    input  wire logic                              i_commit,
    input  wire logic [3:0]                        i_rd_reg,
    output logic [15:0]                            o_rd_data,
    output logic                                   o_freeze,
    output logic [1:0]                             o_mode,
    output logic [1:0]                             o_scale,
    output logic [PRECISION:0]                     o_offset_x,
    output logic [PRECISION:0]                     o_offset_y,
    output logic [PRECISION-1:0]                   o_clip_left,
    output logic [PRECISION-1:0]                   o_clip_right,
    output logic [PRECISION-1:0]                   o_clip_top,
    output logic [PRECISION-1:0]                   o_clip_bottom,
    output logic [TRANSPARENCY_PRECISION:0]        o_opacity
);

    logic                            r_sh_freeze, r_lv_freeze;
    logic [1:0]                      r_sh_mode,   r_lv_mode;
    logic [1:0]                      r_sh_scale,  r_lv_scale;
    logic [7:0]                      r_sh_flags;
    logic [PRECISION:0]              r_sh_offx,   r_lv_offx;
    logic [PRECISION:0]              r_sh_offy,   r_lv_offy;
    logic [PRECISION-1:0]            r_sh_clipl,  r_lv_clipl;
    logic [PRECISION-1:0]            r_sh_clipr,  r_lv_clipr;
    logic [PRECISION-1:0]            r_sh_clipt,  r_lv_clipt;
    logic [PRECISION-1:0]            r_sh_clipb,  r_lv_clipb;
    logic [TRANSPARENCY_PRECISION:0] r_sh_opac,   r_lv_opac;

    // Shadow registers: field writes truncate to field width, RESET restores defaults
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_freeze <= c_DEF_FREEZE;
            r_sh_mode   <= c_DEF_MODE;
            r_sh_scale  <= c_DEF_SCALE;
            r_sh_flags  <= c_DEF_FLAGS;
            r_sh_offx   <= '0;
            r_sh_offy   <= '0;
            r_sh_clipl  <= '0;
            r_sh_clipr  <= '0;
            r_sh_clipt  <= '0;
            r_sh_clipb  <= '0;
            r_sh_opac   <= '1;
        end else if (i_wr_en) begin
            case (i_wr_reg)
                c_REG_RESET: begin
                    r_sh_freeze <= c_DEF_FREEZE;
                    r_sh_mode   <= c_DEF_MODE;
                    r_sh_scale  <= c_DEF_SCALE;
                    r_sh_flags  <= c_DEF_FLAGS;
                    r_sh_offx   <= '0;
                    r_sh_offy   <= '0;
                    r_sh_clipl  <= '0;
                    r_sh_clipr  <= '0;
                    r_sh_clipt  <= '0;
                    r_sh_clipb  <= '0;
                    r_sh_opac   <= '1;
                end
                c_REG_MODE:    r_sh_mode   <= i_wr_data[1:0];
                c_REG_FLAGS:   r_sh_flags  <= i_wr_data[7:0];
                c_REG_SCALE:   r_sh_scale  <= i_wr_data[1:0];
                c_REG_OFFX:    r_sh_offx   <= i_wr_data[PRECISION:0];
                c_REG_OFFY:    r_sh_offy   <= i_wr_data[PRECISION:0];
                c_REG_OPACITY: r_sh_opac   <= i_wr_data[TRANSPARENCY_PRECISION:0];
                c_REG_CLIPL:   r_sh_clipl  <= i_wr_data[PRECISION-1:0];
                c_REG_CLIPR:   r_sh_clipr  <= i_wr_data[PRECISION-1:0];
                c_REG_CLIPT:   r_sh_clipt  <= i_wr_data[PRECISION-1:0];
                c_REG_CLIPB:   r_sh_clipb  <= i_wr_data[PRECISION-1:0];
                c_REG_FREEZE:  r_sh_freeze <= i_wr_data[0];
                default:       ;
            endcase
        end
    end

    // Live registers copy the shadow set whenever commit is asserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lv_freeze <= c_DEF_FREEZE;
            r_lv_mode   <= c_DEF_MODE;
            r_lv_scale  <= c_DEF_SCALE;
            r_lv_offx   <= '0;
            r_lv_offy   <= '0;
            r_lv_clipl  <= '0;
            r_lv_clipr  <= '0;
            r_lv_clipt  <= '0;
            r_lv_clipb  <= '0;
            r_lv_opac   <= '1;
        end else if (i_commit) begin
            r_lv_freeze <= r_sh_freeze;
            r_lv_mode   <= r_sh_mode;
            r_lv_scale  <= r_sh_scale;
            r_lv_offx   <= r_sh_offx;
            r_lv_offy   <= r_sh_offy;
            r_lv_clipl  <= r_sh_clipl;
            r_lv_clipr  <= r_sh_clipr;
            r_lv_clipt  <= r_sh_clipt;
            r_lv_clipb  <= r_sh_clipb;
            r_lv_opac   <= r_sh_opac;
        end
    end

    // Shadow read mux: offsets sign-extend, everything else zero-extends
    always_comb begin
        o_rd_data = 16'h0000;
        case (i_rd_reg)
            c_REG_MODE:    o_rd_data = 16'(r_sh_mode);
            c_REG_FLAGS:   o_rd_data = 16'(r_sh_flags);
            c_REG_SCALE:   o_rd_data = 16'(r_sh_scale);
            c_REG_OFFX:    o_rd_data = 16'($signed(r_sh_offx));
            c_REG_OFFY:    o_rd_data = 16'($signed(r_sh_offy));
            c_REG_OPACITY: o_rd_data = 16'(r_sh_opac);
            c_REG_CLIPL:   o_rd_data = 16'(r_sh_clipl);
            c_REG_CLIPR:   o_rd_data = 16'(r_sh_clipr);
            c_REG_CLIPT:   o_rd_data = 16'(r_sh_clipt);
            c_REG_CLIPB:   o_rd_data = 16'(r_sh_clipb);
            c_REG_FREEZE:  o_rd_data = 16'(r_sh_freeze);
            default:       o_rd_data = 16'h0000;
        endcase
    end

    assign o_freeze      = r_lv_freeze;
    assign o_mode        = r_lv_mode;
    assign o_scale       = r_lv_scale;
    assign o_offset_x    = r_lv_offx;
    assign o_offset_y    = r_lv_offy;
    assign o_clip_left   = r_lv_clipl;
    assign o_clip_right  = r_lv_clipr;
    assign o_clip_top    = r_lv_clipt;
    assign o_clip_bottom = r_lv_clipb;
    assign o_opacity     = r_lv_opac;

endmodule
`default_nettype wire

// File: rtl/pipeline_spi_layer_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_spi_layer_regfile
//  Purpose  : Decodes layer-addressed SPI commands into per-layer shadow
//             registers, answers reads on MISO, and commits shadow to live
//             compositing controls on frame boundaries.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_spi_layer_regfile
    import pipeline_spi_pkg::*;
#(
    parameter int PRECISION              = 11,
    parameter int TRANSPARENCY_PRECISION = 3,
    parameter int NUM_LAYERS             = 2,
    parameter int COMMIT_ON_FRAME        = 1
) (
    input  wire logic                                           clk,
    input  wire logic                                           rst,
    pipeline_spi_layer_regfile_if.slave                         spi,
    input  wire logic                                           frame_start,
    output logic [NUM_LAYERS-1:0]                               ctrl_fg_freeze,
    output logic [2*NUM_LAYERS-1:0]                             ctrl_overlay_mode,
    output logic [2*NUM_LAYERS-1:0]                             ctrl_fg_scale,
    output logic [(PRECISION+1)*NUM_LAYERS-1:0]                 ctrl_fg_offset_x,
    output logic [(PRECISION+1)*NUM_LAYERS-1:0]                 ctrl_fg_offset_y,
    output logic [PRECISION*NUM_LAYERS-1:0]                     ctrl_fg_clip_left,
    output logic [PRECISION*NUM_LAYERS-1:0]                     ctrl_fg_clip_right,
    output logic [PRECISION*NUM_LAYERS-1:0]                     ctrl_fg_clip_top,
    output logic [PRECISION*NUM_LAYERS-1:0]                     ctrl_fg_clip_bottom,
    output logic [(TRANSPARENCY_PRECISION+1)*NUM_LAYERS-1:0]    ctrl_fg_opacity
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARG1    = 2'd1;
    localparam logic [1:0] c_ST_ARG2    = 2'd2;
    localparam logic [1:0] c_ST_PROCESS = 2'd3;

    // Argument register only needs to be as wide as the widest field
    localparam int c_ARG_W = (PRECISION + 1 > 8) ? PRECISION + 1 : 8;

    logic [1:0]         r_state;
    logic               r_read;
    logic [2:0]         r_layer;
    logic [3:0]         r_reg;
    logic [1:0]         r_nargs;
    logic [c_ARG_W-1:0] r_arg;
    logic [15:0]        r_rd_data;
    logic [7:0]         r_abort_cnt;
    logic [7:0]         r_bad_cnt;
    logic [7:0]         r_tx_byte;
    logic               r_tx_valid;

    logic               w_cmd_read;
    logic [2:0]         w_cmd_layer;
    logic [3:0]         w_cmd_reg;
    logic [1:0]         w_cmd_nargs;
    logic               w_cmd_layer_ok;
    logic               w_cmd_global;
    logic [15:0]        w_layer_rd;
    logic [15:0]        w_cmd_rd_value;
    logic               w_wr_base;
    logic               w_commit;
    logic [15:0]        w_bank_rd [NUM_LAYERS];

    assign w_cmd_read     = spi.byte_in[c_CMD_READ_BIT];
    assign w_cmd_layer    = spi.byte_in[c_CMD_LAYER_MSB:c_CMD_LAYER_LSB];
    assign w_cmd_reg      = spi.byte_in[c_CMD_REG_MSB:c_CMD_REG_LSB];
    assign w_cmd_nargs    = arg_count(w_cmd_reg, w_cmd_read);
    assign w_cmd_layer_ok = ({1'b0, w_cmd_layer} < 4'(NUM_LAYERS));
    // STATUS and NOP are not per-layer, so their layer field is ignored
    assign w_cmd_global   = (w_cmd_reg == c_REG_STATUS) || (w_cmd_reg == c_REG_NOP);

    // Select the addressed layer's shadow read data
    always_comb begin
        w_layer_rd = 16'h0000;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (w_cmd_layer == 3'(i)) begin
                w_layer_rd = w_bank_rd[i];
            end
        end
    end

    // Value returned for a read command: status, zero for a missing layer, or bank data
    always_comb begin
        w_cmd_rd_value = 16'h0000;
        if (w_cmd_reg == c_REG_STATUS) begin
            w_cmd_rd_value = {r_abort_cnt, r_bad_cnt};
        end else if (w_cmd_layer_ok) begin
            w_cmd_rd_value = w_layer_rd;
        end
    end

    assign w_wr_base = (r_state == c_ST_PROCESS) && !r_read;
    assign w_commit  = (COMMIT_ON_FRAME != 0) ? frame_start : 1'b1;

    // Command FSM, MISO response and status counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_read      <= 1'b0;
            r_layer     <= 3'd0;
            r_reg       <= 4'd0;
            r_nargs     <= 2'd0;
            r_arg       <= '0;
            r_rd_data   <= 16'h0000;
            r_abort_cnt <= 8'h00;
            r_bad_cnt   <= 8'h00;
            r_tx_byte   <= 8'h00;
            r_tx_valid  <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (spi.spi_active && spi.byte_valid) begin
                        r_read    <= w_cmd_read;
                        r_layer   <= w_cmd_layer;
                        r_reg     <= w_cmd_reg;
                        r_nargs   <= w_cmd_nargs;
                        r_arg     <= '0;
                        r_rd_data <= w_cmd_rd_value;
                        r_state   <= (w_cmd_nargs == 2'd0) ? c_ST_PROCESS : c_ST_ARG1;
                        if (w_cmd_read && (w_cmd_nargs != 2'd0)) begin
                            r_tx_valid <= 1'b1;
                            r_tx_byte  <= (w_cmd_nargs == 2'd2) ? w_cmd_rd_value[15:8]
                                                                : w_cmd_rd_value[7:0];
                        end
                        if (!w_cmd_layer_ok && !w_cmd_global && (r_bad_cnt != 8'hFF)) begin
                            r_bad_cnt <= r_bad_cnt + 8'd1;
                        end
                    end
                end
                c_ST_ARG1, c_ST_ARG2: begin
                    if (!spi.spi_active) begin
                        // Deselect mid-command: discard it and record the abort
                        r_state <= c_ST_IDLE;
                        if (r_abort_cnt != 8'hFF) begin
                            r_abort_cnt <= r_abort_cnt + 8'd1;
                        end
                    end else if (spi.byte_valid) begin
                        if (r_state == c_ST_ARG1) begin
                            r_arg   <= c_ARG_W'(spi.byte_in);
                            r_state <= (r_nargs == 2'd1) ? c_ST_PROCESS : c_ST_ARG2;
                            if (r_read && (r_nargs == 2'd2)) begin
                                r_tx_valid <= 1'b1;
                                r_tx_byte  <= r_rd_data[7:0];
                            end
                        end else begin
                            r_arg   <= c_ARG_W'({r_arg[7:0], spi.byte_in});
                            r_state <= c_ST_PROCESS;
                        end
                    end
                end
                default: begin
                    // PROCESS: the shadow write happens in the banks this cycle
                    r_state <= c_ST_IDLE;
                    if (!r_read && (r_reg == c_REG_STATUS)) begin
                        r_abort_cnt <= 8'h00;
                        r_bad_cnt   <= 8'h00;
                    end
                end
            endcase
        end
    end

    assign spi.tx_byte  = r_tx_byte;
    assign spi.tx_valid = r_tx_valid;

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
            pipeline_spi_layer_bank #(
                .PRECISION              (PRECISION),
                .TRANSPARENCY_PRECISION (TRANSPARENCY_PRECISION),
                .ARG_W                  (c_ARG_W)
            ) u_bank (
                .clk           (clk),
                .rst           (rst),
                .i_wr_en       (w_wr_base && (r_layer == 3'(gi))),
                .i_wr_reg      (r_reg),
                .i_wr_data     (r_arg),
                .i_commit      (w_commit),
                .i_rd_reg      (w_cmd_reg),
                .o_rd_data     (w_bank_rd[gi]),
                .o_freeze      (ctrl_fg_freeze[gi]),
                .o_mode        (ctrl_overlay_mode[2*gi +: 2]),
                .o_scale       (ctrl_fg_scale[2*gi +: 2]),
                .o_offset_x    (ctrl_fg_offset_x[(PRECISION+1)*gi +: PRECISION+1]),
                .o_offset_y    (ctrl_fg_offset_y[(PRECISION+1)*gi +: PRECISION+1]),
                .o_clip_left   (ctrl_fg_clip_left[PRECISION*gi +: PRECISION]),
                .o_clip_right  (ctrl_fg_clip_right[PRECISION*gi +: PRECISION]),
                .o_clip_top    (ctrl_fg_clip_top[PRECISION*gi +: PRECISION]),
                .o_clip_bottom (ctrl_fg_clip_bottom[PRECISION*gi +: PRECISION]),
                .o_opacity     (ctrl_fg_opacity[(TRANSPARENCY_PRECISION+1)*gi +: TRANSPARENCY_PRECISION+1])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipeline_spi_layer_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_spi_layer_regfile
//  Purpose  : Directed self-checking bench for pipeline_spi_layer_regfile
//             (PRECISION=11, TRANSPARENCY_PRECISION=3, NUM_LAYERS=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_spi_layer_regfile;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [1:0]  ctrl_fg_freeze;
    logic [3:0]  ctrl_overlay_mode;
    logic [3:0]  ctrl_fg_scale;
    logic [23:0] ctrl_fg_offset_x;
    logic [23:0] ctrl_fg_offset_y;
    logic [21:0] ctrl_fg_clip_left;
    logic [21:0] ctrl_fg_clip_right;
    logic [21:0] ctrl_fg_clip_top;
    logic [21:0] ctrl_fg_clip_bottom;
    logic [7:0]  ctrl_fg_opacity;

    logic        cap_valid;
    logic [7:0]  cap_byte;
    int          n_vec;
    int          n_err;

    pipeline_spi_layer_regfile_if spi_if ();

    pipeline_spi_layer_regfile #(
        .PRECISION              (11),
        .TRANSPARENCY_PRECISION (3),
        .NUM_LAYERS             (2),
        .COMMIT_ON_FRAME        (1)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .spi                 (spi_if.slave),
        .frame_start         (frame_start),
        .ctrl_fg_freeze      (ctrl_fg_freeze),
        .ctrl_overlay_mode   (ctrl_overlay_mode),
        .ctrl_fg_scale       (ctrl_fg_scale),
        .ctrl_fg_offset_x    (ctrl_fg_offset_x),
        .ctrl_fg_offset_y    (ctrl_fg_offset_y),
        .ctrl_fg_clip_left   (ctrl_fg_clip_left),
        .ctrl_fg_clip_right  (ctrl_fg_clip_right),
        .ctrl_fg_clip_top    (ctrl_fg_clip_top),
        .ctrl_fg_clip_bottom (ctrl_fg_clip_bottom),
        .ctrl_fg_opacity     (ctrl_fg_opacity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparison point: counts every vector, reports and counts miscompares
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One byte strobe, capture MISO the cycle after, then one idle cycle
    task automatic send(input logic [7:0] b);
        spi_if.byte_in    = b;
        spi_if.byte_valid = 1'b1;
        @(posedge clk); #1;
        cap_valid         = spi_if.tx_valid;
        cap_byte          = spi_if.tx_byte;
        spi_if.byte_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(posedge clk); #1;
    endtask

    // Reads STATUS and checks both returned bytes
    task automatic check_status(input string tag, input logic [7:0] abort_exp, input logic [7:0] bad_exp);
        send(8'h8E);
        check({tag, "_hi_v"}, 32'(cap_valid), 32'h1);
        check({tag, "_hi"},   32'(cap_byte),  32'(abort_exp));
        send(8'h00);
        check({tag, "_lo"},   32'(cap_byte),  32'(bad_exp));
        send(8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        cap_valid = 1'b0;
        cap_byte  = 8'h00;
        rst = 1'b1;
        frame_start = 1'b0;
        spi_if.spi_active = 1'b1;
        spi_if.byte_in    = 8'h00;
        spi_if.byte_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        check("rst_freeze",  32'(ctrl_fg_freeze),    32'h0);
        check("rst_mode",    32'(ctrl_overlay_mode), 32'h0);
        check("rst_scale",   32'(ctrl_fg_scale),     32'h0);
        check("rst_offx",    32'(ctrl_fg_offset_x),  32'h0);
        check("rst_offy",    32'(ctrl_fg_offset_y),  32'h0);
        check("rst_clipb",   32'(ctrl_fg_clip_bottom), 32'h0);
        check("rst_opacity", 32'(ctrl_fg_opacity),   32'hFF);
        check("rst_txv",     32'(spi_if.tx_valid),   32'h0);
        check_status("st0", 8'h00, 8'h00);
        check("st0_end_v", 32'(cap_valid), 32'h0);

        // Layer 1 OFFX = 0xF80, visible only after frame_start
        send(8'h14); send(8'h0F); send(8'h80);
        check("offx_pre_frame", 32'(ctrl_fg_offset_x), 32'h0);
        frame();
        check("offx_post_frame", 32'(ctrl_fg_offset_x), 32'hF80000);

        // Sign-extended read of layer 1 OFFX
        send(8'h94);
        check("rd_offx_hi", 32'(cap_byte), 32'hFF);
        send(8'h00);
        check("rd_offx_lo_v", 32'(cap_valid), 32'h1);
        check("rd_offx_lo", 32'(cap_byte), 32'h80);
        send(8'h00);

        // SCALE write whose PROCESS cycle coincides with frame_start
        send(8'h03);
        spi_if.byte_in    = 8'h02;
        spi_if.byte_valid = 1'b1;
        @(posedge clk); #1;
        spi_if.byte_valid = 1'b0;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(posedge clk); #1;
        check("scale_same_frame", 32'(ctrl_fg_scale), 32'h0);
        frame();
        check("scale_next_frame", 32'(ctrl_fg_scale), 32'h2);

        // CLIPL write then 2-byte read
        send(8'h07); send(8'h01); send(8'h23);
        send(8'h87);
        check("rd_clipl_hi_v", 32'(cap_valid), 32'h1);
        check("rd_clipl_hi", 32'(cap_byte), 32'h01);
        send(8'h00);
        check("rd_clipl_lo", 32'(cap_byte), 32'h23);
        send(8'h00);
        check("rd_clipl_end_v", 32'(cap_valid), 32'h0);

        // Abort mid-command, then a normal MODE write
        send(8'h04); send(8'h12);
        spi_if.spi_active = 1'b0;
        @(posedge clk); #1;
        spi_if.spi_active = 1'b1;
        @(posedge clk); #1;
        send(8'h01); send(8'h03);
        frame();
        check("abort_mode", 32'(ctrl_overlay_mode), 32'h3);
        check("abort_offx", 32'(ctrl_fg_offset_x), 32'hF80000);
        check("clipl_live", 32'(ctrl_fg_clip_left), 32'h000123);
        check_status("st_abort", 8'h01, 8'h00);

        // Bad layer writes: no effect, counter increments then saturates
        send(8'h71); send(8'h02);
        frame();
        check("bad_mode", 32'(ctrl_overlay_mode), 32'h3);
        check_status("st_bad1", 8'h01, 8'h01);
        send(8'hF4);
        check("bad_rd_hi", 32'(cap_byte), 32'h00);
        send(8'h00);
        send(8'h00);
        for (int k = 0; k < 298; k++) begin
            send(8'h71); send(8'h02);
        end
        check_status("st_bad_sat", 8'h01, 8'hFF);

        // STATUS write clears both counters
        send(8'h0E);
        check_status("st_clr", 8'h00, 8'h00);

        // Opacity write, then RESET command on layer 0
        send(8'h06); send(8'h05);
        frame();
        check("opacity_wr", 32'(ctrl_fg_opacity), 32'hF5);
        send(8'h00);
        frame();
        check("rst_cmd_opacity", 32'(ctrl_fg_opacity), 32'hFF);
        check("rst_cmd_mode",    32'(ctrl_overlay_mode), 32'h0);
        check("rst_cmd_clipl",   32'(ctrl_fg_clip_left), 32'h0);
        check("rst_cmd_offx",    32'(ctrl_fg_offset_x), 32'hF80000);

        // Freeze on layer 1
        send(8'h1B); send(8'h01);
        frame();
        check("freeze_l1", 32'(ctrl_fg_freeze), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_spi_layer_regfile.md
Name: pipeline_spi_layer_regfile

Overview:
Multi-layer, parametrised successor to the single-foreground SPI command decoder. It consumes the byte stream from spi_slave and decodes layer-addressed write and read commands into a per-layer register bank. Writes go to shadow registers, which are committed to the live pipeline outputs on a frame boundary. It sits between spi_slave and the compositing pipeline and drives every per-layer control vector.

Parameters:
PRECISION, 11, coordinate width; offsets are PRECISION+1 signed, clips are PRECISION unsigned.
TRANSPARENCY_PRECISION, 3, opacity is TRANSPARENCY_PRECISION+1 bits.
NUM_LAYERS, 2, number of overlay layers (1..8).
COMMIT_ON_FRAME, 1, 1 = live registers update only on frame_start; 0 = live tracks shadow the cycle after each write.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
spi_active  in  1  from spi_slave; low = slave deselected
byte_in  in  8  received byte from spi_slave
byte_valid  in  1  one-cycle strobe, byte_in valid
tx_byte  out  8  next MISO byte for spi_slave
tx_valid  out  1  one-cycle strobe, load tx_byte
frame_start  in  1  one-cycle pulse at start of vertical blanking
ctrl_fg_freeze  out  NUM_LAYERS  per-layer freeze
ctrl_overlay_mode  out  2*NUM_LAYERS  per-layer mode, layer i at [2i+1:2i]
ctrl_fg_scale  out  2*NUM_LAYERS  per-layer scale
ctrl_fg_offset_x, ctrl_fg_offset_y  out  (PRECISION+1)*NUM_LAYERS  signed offsets
ctrl_fg_clip_left/right/top/bottom  out  PRECISION*NUM_LAYERS  clips
ctrl_fg_opacity  out  (TRANSPARENCY_PRECISION+1)*NUM_LAYERS  opacity

Behaviour:
- Command byte format: [7] = read, [6:4] = layer, [3:0] = register.
  - Registers: 0 RESET, 1 MODE, 2 FLAGS, 3 SCALE, 4 OFFX, 5 OFFY, 6 OPACITY, 7 CLIPL, 8 CLIPR, 9 CLIPT, A CLIPB, B FREEZE, C/D reserved, E STATUS, F NOP.
  - 0xFF is NOP.
- Argument bytes, big-endian:
  - 0 bytes: regs 0, C, D, F, and E on write.
  - 1 byte: regs 1, 2, 3, 6, B.
  - 2 bytes: regs 4, 5, 7..A, and E on read.
  - Read commands use the same count; the argument bytes are dummy bytes.
- Field widths:
  - Values are truncated to field width (low bits).
  - FLAGS is stored as 8 bits and is not output.
  - Reads return fields zero-extended, except offsets, which are sign-extended to 16 bits.
- FSM states: IDLE, ARG1, ARG2, PROCESS.
  - IDLE + byte_valid: latch command; go to PROCESS if 0-arg, else ARG1.
  - ARG1 + byte_valid: go to PROCESS if 1-arg, else ARG2.
  - ARG2 + byte_valid: go to PROCESS.
  - PROCESS lasts exactly one cycle, then IDLE.
  - The shadow write lands at the end of PROCESS, i.e. 2 cycles after the last byte_valid.
- Read path:
  - tx_byte/tx_valid pulse the cycle after the command byte is accepted (high byte for 2-byte fields, sole byte for 1-byte fields).
  - For 2-byte reads, the low byte pulses the cycle after the first dummy byte.
  - Reads return shadow values.
  - STATUS = {abort_count, bad_layer_count}, two 8-bit saturating counters.
  - Write to E clears both counters.
- Layer index >= NUM_LAYERS:
  - Argument bytes are consumed, no register effect.
  - Read returns 0x00 bytes.
  - bad_layer_count += 1 (saturating at 255).
- RESET command (reg 0): the addressed layer's shadow becomes:
  - mode, scale, offsets, clips, flags, freeze = 0;
  - opacity = all ones.
  - Async rst applies the same values to all shadow and live registers, clears the counters, sets tx_byte=0, tx_valid=0, state=IDLE.
- Commit:
  - With COMMIT_ON_FRAME=1, live <= shadow for all layers on the cycle after frame_start.
  - A PROCESS write in the same cycle as frame_start is not included in that commit; it applies at the next frame.
  - With COMMIT_ON_FRAME=0, live follows shadow with 1-cycle delay.
- spi_active low:
  - FSM goes to IDLE next cycle; any partial command is discarded.
  - If state was ARG1 or ARG2, abort_count += 1 (saturating).
  - A PROCESS in progress completes.
  - A byte_valid in the same cycle is dropped.
- Unknown or reserved registers: arguments consumed, no effect, no error.

Decomposition:
- Package pipeline_spi_pkg:
  - register index constants;
  - command-byte field positions;
  - arg_count(reg, read) function;
  - RESET default values.
- Sub-module pipeline_spi_layer_bank:
  - one layer's shadow and live registers, with write port, read mux and commit input;
  - instantiated NUM_LAYERS times via generate.

Test Plan:
- After rst: all live outputs 0 and opacity = 4'hF; status read 0x8E,00,00 -> tx bytes 0x00, 0x00.
- Write 0x14,0x0F,0x80 (layer 1 OFFX = 0xF80), then frame_start -> layer 1 offset_x = 12'hF80 (-128) only after the pulse; layer 0 unchanged.
- Write 0x03,0x02 with frame_start in its PROCESS cycle -> scale unchanged after that frame, becomes 2 after the next frame_start.
- Read 0x87 (layer 0 CLIPL) after writing 0x07,0x01,0x23 -> tx_byte 0x01 then 0x23, each the cycle after the preceding accepted byte.
- Send 0x04,0x12 then drop spi_active -> no offset change; abort_count = 1; next 0x01,0x03 sets mode = 3 normally.
- With NUM_LAYERS=2, send 0x71,0x02 -> no output change, bad_layer_count = 1; 300 such commands -> saturates at 0xFF.
